// File: rtl/fetch_pkg.sv
// Shared core types for the instruction-fetch stage.
package fetch_pkg;
    typedef logic [63:0] addr_t;
    typedef logic [31:0] instr_t;

    typedef enum logic [1:0] {IDLE, FETCH, DROP, SKID} fetch_state_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
    } fetch_pkt_t;

    localparam addr_t RESET_PC_DEFAULT = 64'h8000_0000;
endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register: load captures, drain empties, flush discards.
module fetch_skid #(
    parameter int W = 96
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         drain,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end else if (drain) begin
            vld <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: PC, instruction-bus requests, and a valid/ready
// output register to decode with a one-entry skid for back-pressure.
module fetch
    import fetch_pkg::*;
#(
    parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc
);
    fetch_state_t state;
    addr_t        pc;
    fetch_pkt_t   skid_d, skid_q;
    logic         skid_vld;

    logic  buf_free, skid_load, skid_drain;
    addr_t pc_inc, target;

    assign buf_free   = !id_valid || id_ready;
    assign pc_inc     = pc + 64'd4;
    assign target     = redirect_pc & ~64'h3;
    assign skid_d     = '{instr: iresp_data, pc: pc};
    assign skid_load  = !redirect_valid && state == FETCH && iresp_data_ok && !buf_free;
    assign skid_drain = !redirect_valid && state == SKID && id_ready;

    fetch_skid #(.W($bits(fetch_pkt_t))) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .drain (skid_drain),
        .flush (redirect_valid),
        .d     (skid_d),
        .vld   (skid_vld),
        .q     (skid_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ireq_valid <= 1'b0;
            ireq_addr  <= RESET_PC;
            id_valid   <= 1'b0;
            id_instr   <= '0;
            id_pc      <= '0;
        end else if (redirect_valid) begin
            pc       <= target;
            id_valid <= 1'b0;
            // A pending request cannot be withdrawn: ride it out in DROP.
            if (ireq_valid && !iresp_data_ok) begin
                state <= DROP;
            end else begin
                state      <= FETCH;
                ireq_valid <= 1'b1;
                ireq_addr  <= target;
            end
        end else begin
            if (id_valid && id_ready)
                id_valid <= 1'b0;
            case (state)
                IDLE: begin
                    state      <= FETCH;
                    ireq_valid <= 1'b1;
                    ireq_addr  <= pc;
                end
                FETCH: begin
                    if (iresp_data_ok) begin
                        pc <= pc_inc;
                        if (buf_free) begin
                            id_valid  <= 1'b1;
                            id_instr  <= iresp_data;
                            id_pc     <= pc;
                            ireq_addr <= pc_inc;
                        end else begin
                            state      <= SKID;
                            ireq_valid <= 1'b0;
                            ireq_addr  <= pc_inc;
                        end
                    end
                end
                SKID: begin
                    if (id_ready && skid_vld) begin
                        id_valid   <= 1'b1;
                        id_instr   <= skid_q.instr;
                        id_pc      <= skid_q.pc;
                        state      <= FETCH;
                        ireq_valid <= 1'b1;
                        ireq_addr  <= pc;
                    end
                end
                DROP: begin
                    if (iresp_data_ok) begin
                        state     <= FETCH;
                        ireq_addr <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
